// File: rtl/chunk_serial_adder.sv
// chunk_serial_adder
//   Multi-cycle unsigned adder: S = A + B + CIN, computed CHUNK bits per
//   clock over WIDTH/CHUNK cycles. The carry between chunks lives in a
//   register, so the combinational carry chain is only CHUNK cells long.
//
// Parameters
//   WIDTH  operand/result width (default 16)
//   CHUNK  bits added per cycle (default 4); WIDTH must be a multiple of CHUNK
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request an operation; accepted whenever busy == 0
//   A, B   addends, sampled on the accepting edge only
//   CIN    carry-in, sampled on the accepting edge only
//   SUB    (only with CHUNK_SERIAL_ADDER_SUB_EN) 1 = compute A - B
//   busy   operation in progress
//   done   one-cycle pulse, S/COUT just updated
//   S      registered sum, updated only when a result completes
//   COUT   registered carry-out of bit WIDTH-1 (for SUB: 1 = no borrow)
//
// Optional feature macro: CHUNK_SERIAL_ADDER_SUB_EN adds the SUB port.
module chunk_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
  input  logic             SUB,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             COUT
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("chunk_serial_adder: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)",
             WIDTH, CHUNK);
    end
  endgenerate

  // Ripple of CHUNK full-adder cells; returns {carry_out, sum}.
  function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] a,
                                               input logic [CHUNK-1:0] b,
                                               input logic             c);
    logic             cy;
    logic [CHUNK-1:0] s;
    cy = c;
    s  = '0;
    for (int i = 0; i < CHUNK; i++) begin
      s[i] = a[i] ^ b[i] ^ cy;
      cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    return {cy, s};
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sh_p0;
  logic [WIDTH-1:0] b_sh_p0;
  logic             carry_p0;
  logic [WIDTH-1:0] acc_p0;
  logic [CNT_W-1:0] cnt_p0;

  logic             accept;
  logic             last_chunk;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic [CHUNK:0]   chunk_res;
  logic [WIDTH-1:0] acc_nxt;

  // Subtraction is A + ~B + 1, so only the latched B and carry differ.
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
  assign b_in = SUB ? ~B : B;
  assign c_in = SUB ? 1'b1 : CIN;
`else
  assign b_in = B;
  assign c_in = CIN;
`endif

  // A new operation may start from IDLE or directly from DONE.
  assign accept     = start && (state != ST_RUN);
  assign last_chunk = (cnt_p0 == LAST_CHUNK);

  // Stage p0 -> chunk sum: low CHUNK bits of both operands plus held carry.
  // The chunk sum enters the accumulator at the MSB end, so after NCHUNK
  // shifts chunk 0 has reached the LSB end. Shift form stays legal when
  // CHUNK == WIDTH.
  assign chunk_res = add_chunk(a_sh_p0[CHUNK-1:0], b_sh_p0[CHUNK-1:0], carry_p0);
  assign acc_nxt   = (acc_p0 >> CHUNK)
                   | (WIDTH'(chunk_res[CHUNK-1:0]) << (WIDTH - CHUNK));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_chunk) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = start ? ST_RUN : ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Stage p0 -> result: S/COUT load only on the edge finishing the last chunk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_p0  <= '0;
      b_sh_p0  <= '0;
      carry_p0 <= 1'b0;
      acc_p0   <= '0;
      cnt_p0   <= '0;
      S        <= '0;
      COUT     <= 1'b0;
    end else if (accept) begin
      a_sh_p0  <= A;
      b_sh_p0  <= b_in;
      carry_p0 <= c_in;
      acc_p0   <= '0;
      cnt_p0   <= '0;
    end else if (state == ST_RUN) begin
      a_sh_p0  <= a_sh_p0 >> CHUNK;
      b_sh_p0  <= b_sh_p0 >> CHUNK;
      carry_p0 <= chunk_res[CHUNK];
      acc_p0   <= acc_nxt;
      cnt_p0   <= cnt_p0 + CNT_W'(1);
      if (last_chunk) begin
        S    <= acc_nxt;
        COUT <= chunk_res[CHUNK];
      end
    end
  end

endmodule
